// File: rtl/srec_writer.sv
// Streams a memory region as Motorola S3 records followed by an S7 terminator,
// one ASCII character per char_valid/char_ready handshake.
module srec_writer #(
    parameter int unsigned MAX_DATA_BYTES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_address,
    input  logic [23:0] length,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [7:0]  mem_data,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready
);

    typedef enum logic [3:0] {
        IDLE, TYPE_S, TYPE_DIGIT, COUNT_HI, COUNT_LO, ADDR, FETCH, CAPTURE,
        DATA_HI, DATA_LO, SUM_HI, SUM_LO, CR, LF, DONE
    } state_t;

    state_t      state;
    logic [31:0] cur_addr;
    logic [31:0] rec_addr;
    logic [23:0] remaining;
    logic [7:0]  rec_count;
    logic [7:0]  byte_idx;
    logic [7:0]  sum;
    logic [7:0]  data_byte;
    logic [2:0]  nib;
    logic        is_s7;

    logic        accept;
    logic        last;
    logic [7:0]  rec_n;
    logic [31:0] rec_a;
    logic [7:0]  sum_init;
    logic [7:0]  count_field;
    logic [7:0]  checksum;
    logic [2:0]  next_nib;
    logic [3:0]  next_addr_nib;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // The S7 terminator is treated as a record with zero data bytes and address 0,
    // which yields count 05 and checksum FA through the common path.
    always_comb begin
        accept        = char_valid & char_ready;
        last          = (remaining == '0);
        rec_n         = last ? 8'd0 :
                        (remaining > 24'(MAX_DATA_BYTES)) ? 8'(MAX_DATA_BYTES) : remaining[7:0];
        rec_a         = last ? '0 : cur_addr;
        sum_init      = (rec_n + 8'd5) + rec_a[31:24] + rec_a[23:16] + rec_a[15:8] + rec_a[7:0];
        count_field   = rec_count + 8'd5;
        checksum      = ~sum;
        next_nib      = nib - 3'd1;
        next_addr_nib = rec_addr[{next_nib, 2'b00} +: 4];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            char_valid  <= 1'b0;
            char_data   <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            cur_addr    <= '0;
            rec_addr    <= '0;
            remaining   <= '0;
            rec_count   <= '0;
            byte_idx    <= '0;
            sum         <= '0;
            data_byte   <= '0;
            nib         <= '0;
            is_s7       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr   <= base_address;
                        remaining  <= length;
                        busy       <= 1'b1;
                        char_valid <= 1'b1;
                        char_data  <= 8'h53;
                        state      <= TYPE_S;
                    end
                end
                TYPE_S: begin
                    // Record parameters are latched while 'S' is on the output.
                    is_s7     <= last;
                    rec_count <= rec_n;
                    byte_idx  <= rec_n;
                    rec_addr  <= rec_a;
                    sum       <= sum_init;
                    if (accept) begin
                        char_data <= last ? 8'h37 : 8'h33;
                        state     <= TYPE_DIGIT;
                    end
                end
                TYPE_DIGIT: if (accept) begin
                    char_data <= hex(count_field[7:4]);
                    state     <= COUNT_HI;
                end
                COUNT_HI: if (accept) begin
                    char_data <= hex(count_field[3:0]);
                    state     <= COUNT_LO;
                end
                COUNT_LO: if (accept) begin
                    nib       <= 3'd7;
                    char_data <= hex(rec_addr[31:28]);
                    state     <= ADDR;
                end
                ADDR: if (accept) begin
                    if (nib != 3'd0) begin
                        nib       <= next_nib;
                        char_data <= hex(next_addr_nib);
                    end else if (byte_idx != '0) begin
                        char_valid  <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= cur_addr;
                        state       <= FETCH;
                    end else begin
                        char_data <= hex(checksum[7:4]);
                        state     <= SUM_HI;
                    end
                end
                FETCH: begin
                    mem_read <= 1'b0;
                    cur_addr <= cur_addr + 32'd1;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    data_byte  <= mem_data;
                    sum        <= sum + mem_data;
                    remaining  <= remaining - 24'd1;
                    byte_idx   <= byte_idx - 8'd1;
                    char_valid <= 1'b1;
                    char_data  <= hex(mem_data[7:4]);
                    state      <= DATA_HI;
                end
                DATA_HI: if (accept) begin
                    char_data <= hex(data_byte[3:0]);
                    state     <= DATA_LO;
                end
                DATA_LO: if (accept) begin
                    if (byte_idx != '0) begin
                        char_valid  <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= cur_addr;
                        state       <= FETCH;
                    end else begin
                        char_data <= hex(checksum[7:4]);
                        state     <= SUM_HI;
                    end
                end
                SUM_HI: if (accept) begin
                    char_data <= hex(checksum[3:0]);
                    state     <= SUM_LO;
                end
                SUM_LO: if (accept) begin
                    char_data <= 8'h0D;
                    state     <= CR;
                end
                CR: if (accept) begin
                    char_data <= 8'h0A;
                    state     <= LF;
                end
                LF: if (accept) begin
                    if (!is_s7) begin
                        char_data <= 8'h53;
                        state     <= TYPE_S;
                    end else begin
                        char_valid <= 1'b0;
                        char_data  <= '0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srec_writer.sv
// Scoreboard bench for srec_writer: a reference model queues the expected
// character and read-address streams, monitors pop and compare them.
module tb_srec_writer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] base_address;
    logic [23:0] length;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_data;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];

    int unsigned acc_count = 0;
    int unsigned rd_count  = 0;
    int unsigned done_cnt  = 0;
    bit          done_flag = 0;
    bit          stall_prev = 0;
    logic [7:0]  prev_data = '0;

    int          ready_mode = 0;
    int unsigned stop_at = 0;
    int unsigned hold_low = 0;

    srec_writer #(.MAX_DATA_BYTES(16)) dut (
        .clock(clock), .reset(reset), .start(start),
        .base_address(base_address), .length(length),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_read(mem_read), .mem_data(mem_data),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] + 8'h01;
    endfunction

    always @(posedge clock) if (mem_read) mem_data <= mem_byte(mem_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_hex8(input logic [7:0] b);
        string hx;
        hx = "0123456789ABCDEF";
        exp_q.push_back(hx[b[7:4]]);
        exp_q.push_back(hx[b[3:0]]);
    endtask

    task automatic build_expected(input logic [31:0] base, input logic [23:0] len);
        logic [31:0] a;
        int unsigned rem, n;
        logic [7:0] s, cnt, d;
        string term;
        a = base;
        rem = len;
        while (rem > 0) begin
            n = (rem > 16) ? 16 : rem;
            exp_q.push_back(8'h53);
            exp_q.push_back(8'h33);
            cnt = 8'(n + 5);
            s = cnt;
            push_hex8(cnt);
            for (int i = 3; i >= 0; i--) begin
                push_hex8(a[i*8 +: 8]);
                s = s + a[i*8 +: 8];
            end
            for (int unsigned k = 0; k < n; k++) begin
                d = mem_byte(a + k);
                push_hex8(d);
                s = s + d;
                addr_q.push_back(a + k);
            end
            push_hex8(~s);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            a = a + n;
            rem = rem - n;
        end
        term = "S70500000000FA";
        for (int i = 0; i < term.len(); i++) exp_q.push_back(term[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (stall_prev)
                check("stall_hold", {23'h0, char_valid, char_data}, {23'h0, 1'b1, prev_data});
            if (char_valid && char_ready) begin
                acc_count++;
                if (exp_q.size() == 0) check("extra_char", 32'(char_valid), 32'h0);
                else check("char", 32'(char_data), 32'(exp_q.pop_front()));
            end
            if (mem_read) begin
                rd_count++;
                if (addr_q.size() == 0) check("extra_read", 32'(mem_read), 32'h0);
                else check("mem_address", mem_address, addr_q.pop_front());
            end
            if (done) begin
                done_flag = 1;
                done_cnt++;
                check("done_after_lf", 32'(exp_q.size()), 32'h0);
            end
            stall_prev = char_valid && !char_ready;
            prev_data  = char_data;
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        char_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: char_ready = 1'b1;
                1: begin
                    if (hold_low > 0) begin
                        char_ready = 1'b0;
                        hold_low--;
                    end else begin
                        char_ready = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 19) == 0) hold_low = $urandom_range(10, 14);
                    end
                end
                default: char_ready = (acc_count < stop_at);
            endcase
        end
    end

    task automatic pulse_start(input logic [31:0] base, input logic [23:0] len);
        @(posedge clock);
        #1;
        start = 1'b1;
        base_address = base;
        length = len;
        @(posedge clock);
        #1;
        start = 1'b0;
        base_address = 32'hDEAD_BEEF;
        length = 24'h00_0007;
    endtask

    task automatic run_dump(input logic [31:0] base, input logic [23:0] len, input bit poke);
        int unsigned cyc;
        build_expected(base, len);
        rd_count = 0;
        done_cnt = 0;
        done_flag = 0;
        pulse_start(base, len);
        check("busy_after_start", 32'(busy), 32'h1);
        if (poke) begin
            repeat (20) @(posedge clock);
            #1;
            start = 1'b1;
            base_address = 32'h0000_5000;
            length = 24'd9;
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        cyc = 0;
        while (!done_flag && cyc < 5000) begin
            @(posedge clock);
            cyc++;
        end
        check("done_seen", 32'(done_flag), 32'h1);
        #1;
        check("busy_cleared", 32'(busy), 32'h0);
        check("chars_left", 32'(exp_q.size()), 32'h0);
        check("reads_left", 32'(addr_q.size()), 32'h0);
        check("read_count", rd_count, 32'(len));
        check("done_count", done_cnt, 32'h1);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int unsigned cyc;
        reset = 1'b1;
        start = 1'b0;
        base_address = '0;
        length = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_char_valid", 32'(char_valid), 32'h0);
        check("rst_char_data", 32'(char_data), 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        reset = 1'b0;

        run_dump(32'h0000_1000, 24'd3, 1'b0);
        run_dump(32'h0000_0000, 24'd20, 1'b1);
        run_dump(32'h1234_5678, 24'd0, 1'b0);
        run_dump(32'h0000_0080, 24'd16, 1'b0);
        run_dump(32'h0000_0080, 24'd17, 1'b0);

        ready_mode = 1;
        hold_low = 12;
        run_dump(32'h0000_1000, 24'd3, 1'b0);
        hold_low = 11;
        run_dump(32'hFFFF_FFFE, 24'd4, 1'b0);

        // Stall on the low data nibble of the first record, then reset.
        ready_mode = 2;
        acc_count = 0;
        stop_at = 15;
        build_expected(32'h0000_2000, 24'd5);
        pulse_start(32'h0000_2000, 24'd5);
        cyc = 0;
        while (acc_count < 15 && cyc < 200) begin
            @(posedge clock);
            cyc++;
        end
        check("reach_data_lo", acc_count, 32'd15);
        repeat (3) @(posedge clock);
        #1;
        check("stall_valid", 32'(char_valid), 32'h1);
        check("stall_lo_char", 32'(char_data), 32'(exp_q[0]));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_char_valid", 32'(char_valid), 32'h0);
        check("mid_rst_char_data", 32'(char_data), 32'h0);
        check("mid_rst_mem_read", 32'(mem_read), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_mem_address", mem_address, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        ready_mode = 0;
        repeat (6) @(posedge clock);
        #1;
        check("idle_no_output", {30'h0, busy, char_valid}, 32'h0);
        run_dump(32'h0000_3000, 24'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
